// File: rtl/dispense_controller_if.sv
// Signal bundle between the vending logic/sensors and the dispense controller.
// The master side drives events and acknowledges; the slave side drives actuators and status.
interface dispense_controller_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          out;
  logic [1:0]    change;
  logic          can_done;
  logic          coin_done;
  logic          clr_err;
  logic          can_motor;
  logic          coin_eject;
  logic          busy;
  logic [CW-1:0] pending;
  logic          overflow;
  logic          fault;

  modport master (
    output out, change, can_done, coin_done, clr_err,
    input  can_motor, coin_eject, busy, pending, overflow, fault
  );

  modport slave (
    input  out, change, can_done, coin_done, clr_err,
    output can_motor, coin_eject, busy, pending, overflow, fault
  );
endinterface

// File: rtl/dispense_controller.sv
// Queues vend/refund events and sequences the can chute and coin hopper in order.
// Define DISPENSE_TIMEOUT_EN to enable the acknowledge timeout and the fault flag.
module dispense_controller #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst,
  dispense_controller_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (TIMEOUT < 1 || TIMEOUT > 255 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
    $error("dispense_controller: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, VEND, COIN_ON, COIN_WAIT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    coins, coins_nxt;
  logic [1:0]    ev_coins;
  logic [2:0]    head;
  logic          capture, full, push, pop, drop;
  logic          tmo_hit;
  logic          overflow;

  always_comb begin
    ev_coins = 2'd0;
    case (bus.change)
      2'b01:   ev_coins = 2'd1;
      2'b10:   ev_coins = 2'd2;
      default: ev_coins = 2'd0;
    endcase
  end

  assign capture = bus.out | (ev_coins != 2'd0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign push    = capture & ~full;
  // A full FIFO drops the event even if IDLE pops in the same cycle.
  assign drop    = capture & full;
  assign pop     = (state == IDLE) && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.out, ev_coins};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)             overflow <= 1'b1;
      else if (bus.clr_err) overflow <= 1'b0;
    end
  end

`ifdef DISPENSE_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       waiting;
  logic       fault;

  assign waiting = (state == VEND) || (state == COIN_WAIT);
  assign tmo_hit = waiting && (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= 8'd0;
      fault   <= 1'b0;
    end else begin
      // Restart on every state change so each acknowledge gets a full window.
      if (!waiting || state_nxt != state) tmo_cnt <= 8'd0;
      else                                tmo_cnt <= tmo_cnt + 8'd1;
      if (tmo_hit)          fault <= 1'b1;
      else if (bus.clr_err) fault <= 1'b0;
    end
  end
  assign bus.fault = fault;
`else
  assign tmo_hit   = 1'b0;
  assign bus.fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      coins <= 2'd0;
    end else begin
      state <= state_nxt;
      coins <= coins_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    coins_nxt = coins;
    case (state)
      IDLE: begin
        if (pop) begin
          coins_nxt = head[1:0];
          state_nxt = head[2] ? VEND : COIN_ON;
        end
      end
      VEND: begin
        if (bus.can_done) begin
          state_nxt = (coins != 2'd0) ? COIN_ON : IDLE;
        end else if (tmo_hit) begin
          coins_nxt = 2'd0;
          state_nxt = IDLE;
        end
      end
      COIN_ON: state_nxt = COIN_WAIT;
      COIN_WAIT: begin
        if (bus.coin_done) begin
          coins_nxt = coins - 2'd1;
          state_nxt = (coins > 2'd1) ? COIN_ON : IDLE;
        end else if (tmo_hit) begin
          coins_nxt = 2'd0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.can_motor  = (state == VEND);
  assign bus.coin_eject = (state == COIN_ON);
  assign bus.busy       = (state != IDLE) || (count != '0);
  assign bus.pending    = count;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_dispense_controller.sv
// Scoreboard bench for dispense_controller: stimulus queues expected actuator runs,
// a monitor checks each completed can_motor run and coin_eject pulse against them.
module tb_dispense_controller;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 255;

  typedef struct packed {
    logic        coin;
    logic [15:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   vend_delay = 11;
  int   coin_delay = 3;
  int   mcnt = 0;
  int   ccnt = 0;
  int   mlen = 0;
  int   clen = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dispense_controller_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  dispense_controller #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sensor model: acknowledge the chute after vend_delay motor cycles, the hopper coin_delay cycles after a pulse.
  always @(negedge clk) begin
    if (!rst) begin
      mcnt = 0; ccnt = 0;
      bus.can_done = 1'b0; bus.coin_done = 1'b0;
    end else begin
      bus.can_done = 1'b0; bus.coin_done = 1'b0;
      if (bus.can_motor) begin
        mcnt++;
        if (mcnt == vend_delay) bus.can_done = 1'b1;
      end else mcnt = 0;
      if (bus.coin_eject) ccnt = 1;
      else if (ccnt > 0) begin
        ccnt++;
        if (ccnt == coin_delay + 1) begin
          bus.coin_done = 1'b1;
          ccnt = 0;
        end
      end
    end
  end

  // Monitor: compare each finished motor run / eject pulse with the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      mlen = 0; clen = 0;
    end else begin
      if (bus.can_motor) mlen++;
      else if (mlen > 0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL unexpected_motor: got run of %0d cycles, expected none", mlen);
        end else begin
          e = exp_q.pop_front();
          if (e.coin !== 1'b0 || e.len != 16'(mlen)) begin
            fails++;
            $display("FAIL motor_run: got motor run %0d, expected coin=%0d len=%0d", mlen, e.coin, e.len);
          end
        end
        mlen = 0;
      end
      if (bus.coin_eject) clen++;
      else if (clen > 0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL unexpected_eject: got pulse of %0d cycles, expected none", clen);
        end else begin
          e = exp_q.pop_front();
          if (e.coin !== 1'b1 || e.len != 16'(clen)) begin
            fails++;
            $display("FAIL eject_pulse: got eject width %0d, expected coin=%0d len=%0d", clen, e.coin, e.len);
          end
        end
        clen = 0;
      end
    end
  end

  task automatic expect_entry(input logic o, input logic [1:0] ch);
    if (o) exp_q.push_back('{coin: 1'b0, len: 16'(vend_delay)});
    if (ch == 2'b01 || ch == 2'b10) exp_q.push_back('{coin: 1'b1, len: 16'd1});
    if (ch == 2'b10) exp_q.push_back('{coin: 1'b1, len: 16'd1});
  endtask

  task automatic issue(input logic o, input logic [1:0] ch);
    expect_entry(o, ch);
    @(negedge clk);
    bus.out = o; bus.change = ch;
    @(negedge clk);
    bus.out = 1'b0; bus.change = 2'b00;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #1;
    check({name, "_idle"}, bus.busy, 1'b0);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out = 1'b0; bus.change = 2'b00; bus.clr_err = 1'b0;
    #23;
    check("rst_motor", bus.can_motor, 1'b0);
    check("rst_eject", bus.coin_eject, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_pending", bus.pending, 0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_fault", bus.fault, 1'b0);
    @(negedge clk); rst = 1'b1;

    // Vend only: latency of one edge after capture, motor for vend_delay cycles.
    vend_delay = 11;
    issue(1'b1, 2'b00);
    #1;
    check("vend_pend_e", bus.pending, 1);
    check("vend_motor_e", bus.can_motor, 1'b0);
    @(negedge clk); #1;
    check("vend_motor_e1", bus.can_motor, 1'b1);
    check("vend_pend_e1", bus.pending, 0);
    wait_idle("vend", 100);

    // 10c refund: two separately acknowledged pulses.
    issue(1'b0, 2'b10);
    @(negedge clk); #1;
    check("refund_eject_e1", bus.coin_eject, 1'b1);
    wait_idle("refund", 100);

    // Combined vend + 5c.
    vend_delay = 6;
    issue(1'b1, 2'b01);
    #1;
    check("comb_pend1", bus.pending, 1);
    @(negedge clk); #1;
    check("comb_pend0", bus.pending, 0);
    wait_idle("comb", 100);

    // Code 11 is no event.
    issue(1'b0, 2'b11);
    #1;
    check("code11_pend", bus.pending, 0);
    wait_idle("code11", 10);

    // Overflow: six back-to-back vends with a slow chute.
    vend_delay = 40;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.out = 1'b1;
      if (i < 5) expect_entry(1'b1, 2'b00);
      @(negedge clk);
    end
    bus.out = 1'b0;
    #1;
    check("ovf_pending", bus.pending, FIFO_DEPTH);
    check("ovf_flag", bus.overflow, 1'b1);
    @(negedge clk); bus.clr_err = 1'b1; bus.out = 1'b1;
    @(negedge clk); bus.clr_err = 1'b0; bus.out = 1'b0; #1;
    check("ovf_set_wins", bus.overflow, 1'b1);
    @(negedge clk); bus.clr_err = 1'b1;
    @(negedge clk); bus.clr_err = 1'b0; #1;
    check("ovf_cleared", bus.overflow, 1'b0);
    check("ovf_pending_kept", bus.pending, FIFO_DEPTH);
    wait_idle("ovf", 600);

`ifdef DISPENSE_TIMEOUT_EN
    // Timeout: chute never acknowledges; coin of that entry is discarded, next entry runs.
    vend_delay = 1000;
    exp_q.push_back('{coin: 1'b0, len: 16'(TIMEOUT)});
    @(negedge clk); bus.out = 1'b1; bus.change = 2'b01;
    @(negedge clk); bus.out = 1'b0; bus.change = 2'b01;
    expect_entry(1'b0, 2'b01);
    @(negedge clk); bus.change = 2'b00;
    wait_idle("tmo", 400);
    check("tmo_fault", bus.fault, 1'b1);
    @(negedge clk); bus.clr_err = 1'b1;
    @(negedge clk); bus.clr_err = 1'b0; #1;
    check("tmo_fault_clr", bus.fault, 1'b0);
`else
    check("fault_off", bus.fault, 1'b0);
`endif

    // Asynchronous reset mid-vend with two entries queued.
    vend_delay = 40;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.out = 1'b1;
      @(negedge clk);
    end
    bus.out = 1'b0;
    #1;
    check("rstmid_pending", bus.pending, 2);
    check("rstmid_motor_on", bus.can_motor, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rstmid_motor", bus.can_motor, 1'b0);
    check("rstmid_pend0", bus.pending, 0);
    check("rstmid_busy", bus.busy, 1'b0);
    @(negedge clk); exp_q.delete();
    @(negedge clk); rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("post_rst_motor", bus.can_motor, 1'b0);
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
